// File: rtl/uart_stream_ctrl_pkg.sv
// uart_pkg: UART register map, STAT bit positions and controller states.
// Shared by the memory interface, the stream controller and its bench.
package uart_pkg;

  localparam logic [3:0] REG_RX   = 4'h0;
  localparam logic [3:0] REG_TX   = 4'h4;
  localparam logic [3:0] REG_STAT = 4'h8;
  localparam logic [3:0] REG_CTRL = 4'hC;

  localparam int STAT_RX_VALID = 0;
  localparam int STAT_RX_FULL  = 1;
  localparam int STAT_TX_FULL  = 3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_POLL_REQ,
    S_POLL_RSP,
    S_TX_REQ,
    S_TX_RSP,
    S_RX_REQ,
    S_RX_RSP,
    S_GAP
  } state_t;

  function automatic logic [31:0] reg_addr(
    input logic [31:0] base,
    input logic [3:0]  off
  );
    return base + {28'b0, off};
  endfunction

endpackage

// File: rtl/uart_stream_ctrl_if.sv
// scarv_ccx_memif: single-outstanding request/grant memory port.
// REQ side drives req/wen/strb/addr/wdata; rdata/error arrive next cycle.
interface scarv_ccx_memif;

  logic        req;
  logic        gnt;
  logic        wen;
  logic [3:0]  strb;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        error;

  modport REQ (
    output req, wen, strb, addr, wdata,
    input  gnt, rdata, error
  );

  modport RSP (
    input  req, wen, strb, addr, wdata,
    output gnt, rdata, error
  );

endinterface

// File: rtl/uart_stream_ctrl.sv
// uart_stream_ctrl: polls UART STAT and moves bytes between streams and
// the UART data registers over one memif, round-robin between RX and TX.
//
// Ports:
//   g_clk, g_resetn        clock, async active-low reset
//   g_clk_req              clock request (busy / enabled / byte held)
//   enable                 run the polling loop
//   tx_valid/data/ready    inbound byte stream (ready = write granted)
//   rx_valid/data/ready    outbound byte stream (one-byte holding reg)
//   err, err_clr           sticky bus error and its clear
//   tx_count, rx_count     wrapping transfer counters
//   memif                  request side of the UART register port
import uart_pkg::*;

module uart_stream_ctrl #(
  parameter logic [31:0] UART_BASE = 32'h4000_1000,
  parameter int unsigned POLL_GAP  = 4
) (
  input  logic         g_clk,
  input  logic         g_resetn,
  output logic         g_clk_req,
  input  logic         enable,
  input  logic         tx_valid,
  input  logic [7:0]   tx_data,
  output logic         tx_ready,
  output logic         rx_valid,
  output logic [7:0]   rx_data,
  input  logic         rx_ready,
  output logic         err,
  input  logic         err_clr,
  output logic [15:0]  tx_count,
  output logic [15:0]  rx_count,
  scarv_ccx_memif.REQ  memif
);

  localparam int GW =
    (POLL_GAP > 0) ? $clog2(POLL_GAP + 1) : 1;
  localparam logic [GW-1:0] GAP_LAST =
    GW'((POLL_GAP > 0) ? POLL_GAP - 1 : 0);
  localparam state_t AFTER_IDLE_POLL =
    (POLL_GAP == 0) ? S_POLL_REQ : S_GAP;

  state_t        state;
  state_t        state_nx;
  logic [GW-1:0] gap_q;
  logic          last_rx;

  logic stat_rx;
  logic stat_txf;
  logic rx_elig;
  logic tx_elig;
  logic take_rx;
  logic take_tx;
  logic in_rsp;
  logic rsp_err;
  logic gap_done;
  logic unused_rdata;

  assign stat_rx  = memif.rdata[STAT_RX_VALID];
  assign stat_txf = memif.rdata[STAT_TX_FULL];
  assign rx_elig  = stat_rx && !rx_valid;
  assign tx_elig  = !stat_txf && tx_valid;

  // When both sides want the bus, the one served last time yields.
  assign take_rx = rx_elig && (!tx_elig || !last_rx);
  assign take_tx = tx_elig && !take_rx;

  assign in_rsp = (state == S_POLL_RSP) ||
                  (state == S_TX_RSP)   ||
                  (state == S_RX_RSP);
  assign rsp_err  = in_rsp && memif.error;
  assign gap_done = (gap_q == GAP_LAST);

  assign g_clk_req = enable || (state != S_IDLE) || rx_valid;

  assign unused_rdata = ^memif.rdata[31:8];

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Request outputs are decoded from state alone, so they stay put
  // for as long as a request waits on gnt and vanish with reset.
  always_comb begin
    state_nx    = state;
    memif.req   = 1'b0;
    memif.wen   = 1'b0;
    memif.strb  = 4'b0000;
    memif.addr  = 32'b0;
    memif.wdata = 32'b0;
    tx_ready    = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (enable) state_nx = S_POLL_REQ;
      end
      S_POLL_REQ: begin
        memif.req  = 1'b1;
        memif.addr = reg_addr(UART_BASE, REG_STAT);
        if (memif.gnt) state_nx = S_POLL_RSP;
      end
      S_POLL_RSP: begin
        if (!enable)           state_nx = S_IDLE;
        else if (memif.error)  state_nx = AFTER_IDLE_POLL;
        else if (take_rx)      state_nx = S_RX_REQ;
        else if (take_tx)      state_nx = S_TX_REQ;
        else                   state_nx = AFTER_IDLE_POLL;
      end
      S_TX_REQ: begin
        memif.req   = 1'b1;
        memif.wen   = 1'b1;
        memif.strb  = 4'b0001;
        memif.addr  = reg_addr(UART_BASE, REG_TX);
        memif.wdata = {24'b0, tx_data};
        tx_ready    = memif.gnt;
        if (memif.gnt) state_nx = S_TX_RSP;
      end
      S_RX_REQ: begin
        memif.req  = 1'b1;
        memif.addr = reg_addr(UART_BASE, REG_RX);
        if (memif.gnt) state_nx = S_RX_RSP;
      end
      S_TX_RSP,
      S_RX_RSP: begin
        if (!enable)          state_nx = S_IDLE;
        else if (memif.error) state_nx = AFTER_IDLE_POLL;
        else                  state_nx = S_POLL_REQ;
      end
      S_GAP: begin
        if (!enable)       state_nx = S_IDLE;
        else if (gap_done) state_nx = S_POLL_REQ;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      gap_q <= '0;
    end else if (state == S_GAP && !gap_done) begin
      gap_q <= gap_q + GW'(1);
    end else begin
      gap_q <= '0;
    end
  end

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      last_rx <= 1'b0;
    end else if (state == S_POLL_RSP && enable &&
                 !memif.error) begin
      if (take_rx)      last_rx <= 1'b1;
      else if (take_tx) last_rx <= 1'b0;
    end
  end

  // A capture in RX_RSP only happens when the holding register was
  // empty at the preceding poll, so it never overwrites a held byte.
  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      rx_valid <= 1'b0;
      rx_data  <= 8'h00;
      rx_count <= 16'h0000;
    end else begin
      if (rx_valid && rx_ready) rx_valid <= 1'b0;
      if (state == S_RX_RSP && !memif.error) begin
        rx_valid <= 1'b1;
        rx_data  <= memif.rdata[7:0];
        rx_count <= rx_count + 16'd1;
      end
    end
  end

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      tx_count <= 16'h0000;
    end else if (state == S_TX_RSP && !memif.error) begin
      tx_count <= tx_count + 16'd1;
    end
  end

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      err <= 1'b0;
    end else if (rsp_err) begin
      err <= 1'b1;
    end else if (err_clr) begin
      err <= 1'b0;
    end
  end

endmodule

// File: doc/uart_stream_ctrl.md
# uart_stream_ctrl

Bus-mastering controller that sequences the UART peripheral through its memory-mapped register interface. It turns the register protocol (STAT polling, TX/RX data registers) into a pair of byte streams: a transmit stream in, a receive stream out. It sits between a byte producer/consumer (boot loader, debug monitor) and the UART's request port. It arbitrates round-robin between RX drains and TX fills over the single memif.

## Interface
- `UART_BASE`, default 32'h4000_1000: UART base address. RX is at +0x0, TX at +0x4, STAT at +0x8.
- `POLL_GAP`, default 4: idle cycles inserted after a STAT poll that found nothing to do. 0 means back-to-back polling.
- `g_clk`  in  1  single clock.
- `g_resetn`  in  1  reset, asynchronous and active-low.
- `g_clk_req`  out  1  clock request.
- `enable`  in  1  run the controller.
- `tx_valid`  in  1  TX byte offered.
- `tx_data`  in  8  TX byte.
- `tx_ready`  out  1  TX byte consumed this cycle.
- `rx_valid`  out  1  RX byte held.
- `rx_data`  out  8  RX byte.
- `rx_ready`  in  1  consumer takes RX byte.
- `err`  out  1  sticky bus error.
- `err_clr`  in  1  clear `err`.
- `tx_count`  out  16  bytes written to the UART, wrapping.
- `rx_count`  out  16  bytes read from the UART, wrapping.
- `memif`  scarv_ccx_memif.REQ  request-side memory interface. Signals: req, gnt, wen, strb, addr, wdata, rdata, error.

## Operation
- **FSM states:** IDLE, POLL_REQ, POLL_RSP, TX_REQ, TX_RSP, RX_REQ, RX_RSP, GAP.
- **IDLE:**
  - Moves to POLL_REQ when `enable=1`.
  - When `enable=0` mid-run, the current transaction completes through its *_RSP state, then the FSM goes to IDLE instead of POLL_REQ/GAP.
- **POLL_REQ:** drives req=1, wen=0, addr=UART_BASE+8, held until gnt.
- **POLL_RSP:** samples rdata. STAT bit0 = rx_valid, bit3 = tx_full.
  - RX is eligible when bit0=1 and the RX holding register is empty.
  - TX is eligible when bit3=0 and `tx_valid=1`.
  - Both eligible: take the one not taken last (`last_rx` flag, reset 0, so RX wins first).
  - One eligible: take it.
  - None eligible: go to GAP.
- **TX_REQ:**
  - Drives req=1, wen=1, strb=4'b0001, addr=UART_BASE+4, wdata={24'b0, tx_data}.
  - `tx_ready` = req && gnt (single-cycle pulse).
  - Producer must hold `tx_valid`/`tx_data` stable until `tx_ready`.
- **RX_REQ:** drives req=1, wen=0, addr=UART_BASE+0.
- **RX_RSP:**
  - If no error: rx_data <= rdata[7:0], rx_valid <= 1, rx_count++.
  - `rx_valid` falls on the cycle after `rx_valid && rx_ready`.
- **TX_RSP:** if no error, tx_count++.
- **Bus error:** `memif.error=1` in any *_RSP state:
  - sets `err`;
  - suppresses the count increment and RX capture;
  - sends the FSM to GAP.
- **err_clr:** clears `err`. A set in the same cycle wins.
- **After a transfer:** successful TX_RSP/RX_RSP returns to POLL_REQ.
- **GAP:** counts POLL_GAP cycles, then goes to POLL_REQ. With POLL_GAP=0, GAP is skipped and the FSM goes straight to POLL_REQ.
- **Request stability:** req is never withdrawn, and addr/wen/wdata/strb never change, while req=1 and gnt=0.
- **Clock request:** g_clk_req = enable || state!=IDLE || rx_valid.
- **Reset values:**
  - state=IDLE, req=0, wen=0, addr=0, wdata=0, strb=0;
  - tx_ready=0, rx_valid=0, rx_data=0, err=0;
  - counts=0, last_rx=0, gap counter=0.

## Timing
- **Response timing:** rdata and error are valid in the cycle after the req&&gnt cycle (the *_RSP state).
- **TX throughput:** with gnt always 1, one TX byte takes 4 cycles (POLL_REQ, POLL_RSP, TX_REQ, TX_RSP). `tx_ready` pulses in the 3rd cycle.
- **RX latency:** `rx_valid` rises the cycle after RX_RSP.
- **Idle poll period:** POLL_GAP+2 cycles.
- **Counters:** 16-bit, wrap 0xFFFF→0x0000 with no flag.
- **Reset:** asynchronous assert mid-transaction drops req immediately. Deassertion is synchronised by the system. The first req appears ≥1 cycle after reset release with `enable=1`.

## Structure
- Package `uart_pkg`:
  - register offsets RX=4'h0, TX=4'h4, STAT=4'h8, CTRL=4'hC;
  - STAT bit indices (RX_VALID=0, RX_FULL=1, TX_FULL=3);
  - the FSM state enum.
- Single module. The RX holding register is inline; no sub-module is needed.
- Gap counter width: $clog2(POLL_GAP+1), minimum 1.

## Test plan
- **TX single byte:** gnt=1, STAT=0x00, tx_valid with 0x5A → write to BASE+4, wdata=0x0000005A, strb=1; tx_ready pulses once; tx_count=1.
- **RX single byte:** STAT=0x01, RX reads 0x000000C3 → rx_data=0xC3, rx_valid held until rx_ready; no further RX read while held; rx_count=1.
- **Round-robin:** STAT=0x01 on every poll, tx_valid always high → access sequence RX, TX, RX, TX.
- **Backpressure:**
  - STAT=0x08 with tx_valid → no TX write;
  - polls spaced POLL_GAP+2=6 cycles apart;
  - gnt held low 3 cycles on a TX_REQ → addr/wdata stable, tx_ready only in the gnt cycle.
- **Error:** error=1 on an RX_RSP → err=1, rx_valid stays 0, rx_count unchanged; err_clr in the same cycle as a new error → err stays 1.
- **Stop/reset:**
  - enable dropped during TX_REQ → write completes, then IDLE and g_clk_req=0;
  - g_resetn low mid-RX_REQ → req=0 asynchronously, all outputs at reset values.
